bg_line_fetcher: RTL and testbench
==================================

Name: bg_line_fetcher

Overview:
- Downstream consumer of the background-manager AXI4-Lite register outputs (enable, scroll X/Y).
- Once per scanline, walks one row of the 64x64 background tilemap in block RAM.
- Writes the 41 tile indices that cover the next visible line into the line tile buffer.
- The pixel stage reads that buffer during active video.

Parameters:
- TILE_LOG2, 4, log2 of tile edge in pixels (16x16 tiles)
- MAP_W_LOG2, 6, log2 of map width and height in tiles (64x64 map)
- FETCH_TILES, 41, tiles fetched per line (40 visible plus 1 for fine-scroll spill)
- IDX_W, 8, tile index width

Ports:
- ACLK  in  1  system clock
- ARESET  in  1  synchronous, active-high reset
- cfg_enable  in  1  background enable, from register 0 bit 0
- cfg_scroll_x  in  10  horizontal scroll in pixels, from register 1
- cfg_scroll_y  in  10  vertical scroll in pixels, from register 2
- line_start  in  1  single-cycle pulse requesting a fetch for the next line
- line_y  in  10  screen Y of the next line; valid with line_start
- map_rd_en  out  1  tilemap BRAM read enable
- map_addr  out  12  tilemap address {tile_row[5:0], tile_col[5:0]}
- map_rd_data  in  8  tilemap data; valid exactly 1 cycle after map_rd_en
- buf_wr_en  out  1  line tile buffer write strobe
- buf_wr_addr  out  6  buffer slot, 0..40
- buf_wr_tile  out  8  tile index written
- fine_x  out  4  pixel offset into first tile; held for the whole line
- fine_row  out  4  pixel row inside the tile row; held for the whole line
- busy  out  1  high from the cycle after acceptance until line_done
- line_done  out  1  one-cycle pulse when the last buffer write has completed
- overrun_cnt  out  8  saturating count of line_start pulses dropped while busy

Behaviour:
- Reset: state IDLE. All outputs 0, including fine_x, fine_row and overrun_cnt. Any in-progress fetch is abandoned and no further writes occur. ARESET takes priority over every other input in the same cycle.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE to FETCH on line_start=1 with cfg_enable=1. At that edge, latch:
  - map_y = (line_y + cfg_scroll_y) mod 1024
  - tile_row = map_y[9:4]
  - fine_row = map_y[3:0]
  - start_col = cfg_scroll_x[9:4]
  - fine_x = cfg_scroll_x[3:0]
- line_start with cfg_enable=0 in IDLE: ignored; no reads, no writes, no line_done, overrun_cnt unchanged.
- Configuration is sampled only at acceptance. cfg_* changes during a fetch have no effect on the current line.
- FETCH:
  - Counter k runs 0..FETCH_TILES-1, one read per cycle, no stalls.
  - map_rd_en=1, map_addr = {tile_row, (start_col + k) mod 64}; column wraps from 63 to 0.
  - After issuing k=40, go to DRAIN.
- Write path:
  - One cycle after each read, buf_wr_en=1, buf_wr_addr = k of that read, buf_wr_tile = map_rd_data.
  - Writes are contiguous and ascending from 0 to 40.
- DRAIN: no read; completes the final write (slot 40); go to DONE.
- DONE: line_done=1 for one cycle; return to IDLE. A line_start in this cycle counts as an overrun.
- Timing, with acceptance edge = cycle 0:
  - reads at cycles 1..41
  - writes at cycles 2..42
  - line_done at cycle 43
  - busy high on cycles 1..43
  - next line_start accepted no earlier than cycle 44
- Overrun: line_start while in FETCH, DRAIN or DONE is dropped. overrun_cnt increments by 1 and saturates at 255; the current fetch continues undisturbed.
- Arithmetic: all sums are unsigned with truncation; wrap-around is modulo the field width. No divide or multiply; shifts and bit selects only.
- map_rd_en is high only in FETCH. buf_wr_en is high only on cycles 2..42.

Test Plan:
- Reset, cfg_enable=1, scroll_x=0, scroll_y=0, line_start with line_y=0 -> map_addr 0x000..0x028 on cycles 1..41; buf slots 0..40 hold map[0..40]; fine_x=0, fine_row=0; line_done at cycle 43.
- scroll_x=0x3F5 (start_col 63, fine_x 5), scroll_y=0x010, line_y=3 -> tile_row 1, fine_row 3; addresses 0x07F, 0x040, 0x041..0x067 (column wraps 63 to 0); slot 0 = map[0x07F], slot 1 = map[0x040].
- scroll_y=0x3FE, line_y=5 -> map_y=3; tile_row 0, fine_row 3 (vertical wrap).
- line_start on cycles 10, 20 and 43 of a fetch -> all dropped; overrun_cnt=3; writes still complete at cycle 42 with unchanged data; 300 drops -> overrun_cnt=255.
- cfg_enable=0 plus line_start -> no map_rd_en, no buf_wr_en, no line_done. Changing scroll_x mid-fetch -> addresses unchanged for the current line.
- ARESET asserted at cycle 20 of a fetch -> next cycle all outputs 0, state IDLE, no writes after cycle 20. A subsequent line_start is accepted normally.

Source files
------------

// File: rtl/bg_line_fetcher.sv
// Per-scanline background tile fetcher: walks one tilemap row from block RAM and
// fills the line tile buffer with the tile indices covering the next visible line.
module bg_line_fetcher #(
    parameter int TILE_LOG2   = 4,
    parameter int MAP_W_LOG2  = 6,
    parameter int FETCH_TILES = 41,
    parameter int IDX_W       = 8
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      cfg_enable,
    input  logic [9:0]                cfg_scroll_x,
    input  logic [9:0]                cfg_scroll_y,
    input  logic                      line_start,
    input  logic [9:0]                line_y,
    output logic                      map_rd_en,
    output logic [2*MAP_W_LOG2-1:0]   map_addr,
    input  logic [IDX_W-1:0]          map_rd_data,
    output logic                      buf_wr_en,
    output logic [5:0]                buf_wr_addr,
    output logic [IDX_W-1:0]          buf_wr_tile,
    output logic [TILE_LOG2-1:0]      fine_x,
    output logic [TILE_LOG2-1:0]      fine_row,
    output logic                      busy,
    output logic                      line_done,
    output logic [7:0]                overrun_cnt
);

    localparam int PIX_W = TILE_LOG2 + MAP_W_LOG2;
    localparam logic [5:0] K_LAST = 6'(FETCH_TILES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state;
    logic [5:0]            k;
    logic [MAP_W_LOG2-1:0] tile_row;
    logic [MAP_W_LOG2-1:0] start_col;
    logic [MAP_W_LOG2-1:0] col;
    logic [PIX_W-1:0]      map_y;
    logic                  wr_en_q;
    logic [5:0]            wr_addr_q;

    // line_start is a one-cycle request with no ready: it is taken only in IDLE
    // with cfg_enable set; in any other state it is dropped and counted.
    assign map_y = line_y + cfg_scroll_y;
    assign col   = start_col + k[MAP_W_LOG2-1:0];

    assign map_rd_en   = (state == S_FETCH);
    assign map_addr    = map_rd_en ? {tile_row, col} : '0;
    assign buf_wr_en   = wr_en_q;
    assign buf_wr_addr = wr_en_q ? wr_addr_q : '0;
    assign buf_wr_tile = wr_en_q ? map_rd_data : '0;
    assign busy        = (state != S_IDLE);
    assign line_done   = (state == S_DONE);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state       <= S_IDLE;
            k           <= '0;
            tile_row    <= '0;
            start_col   <= '0;
            fine_x      <= '0;
            fine_row    <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            overrun_cnt <= '0;
        end else begin
            // BRAM data lands one cycle after the read, so the write trails by one.
            wr_en_q   <= (state == S_FETCH);
            wr_addr_q <= k;

            if (line_start && (state != S_IDLE) && (overrun_cnt != 8'hFF))
                overrun_cnt <= overrun_cnt + 8'd1;

            case (state)
                S_IDLE: begin
                    if (line_start && cfg_enable) begin
                        state     <= S_FETCH;
                        k         <= '0;
                        tile_row  <= map_y[PIX_W-1:TILE_LOG2];
                        fine_row  <= map_y[TILE_LOG2-1:0];
                        start_col <= cfg_scroll_x[PIX_W-1:TILE_LOG2];
                        fine_x    <= cfg_scroll_x[TILE_LOG2-1:0];
                    end
                end
                S_FETCH: begin
                    if (k == K_LAST)
                        state <= S_DRAIN;
                    else
                        k <= k + 6'd1;
                end
                S_DRAIN: state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bg_line_fetcher.sv
// Bench for bg_line_fetcher: BRAM tilemap model, scoreboard of expected reads
// and buffer writes, and per-cycle control timing checks for each scenario.
module tb_bg_line_fetcher;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cfg_enable;
    logic [9:0]  cfg_scroll_x;
    logic [9:0]  cfg_scroll_y;
    logic        line_start;
    logic [9:0]  line_y;
    logic        map_rd_en;
    logic [11:0] map_addr;
    logic [7:0]  map_rd_data;
    logic        buf_wr_en;
    logic [5:0]  buf_wr_addr;
    logic [7:0]  buf_wr_tile;
    logic [3:0]  fine_x;
    logic [3:0]  fine_row;
    logic        busy;
    logic        line_done;
    logic [7:0]  overrun_cnt;

    int checks = 0;
    int failures = 0;
    int exp_ovr = 0;

    logic [7:0]  tmap [0:4095];
    logic [7:0]  rd_q = 8'h00;
    logic [11:0] exp_addr_q[$];
    logic [13:0] exp_wr_q[$];
    logic [11:0] obs_addr [0:40];
    logic [11:0] ea;
    logic [13:0] ew;

    bg_line_fetcher dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cfg_enable(cfg_enable), .cfg_scroll_x(cfg_scroll_x), .cfg_scroll_y(cfg_scroll_y),
        .line_start(line_start), .line_y(line_y),
        .map_rd_en(map_rd_en), .map_addr(map_addr), .map_rd_data(map_rd_data),
        .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_tile(buf_wr_tile),
        .fine_x(fine_x), .fine_row(fine_row), .busy(busy), .line_done(line_done),
        .overrun_cnt(overrun_cnt)
    );

    // clock and tilemap BRAM model (one-cycle read latency)
    initial forever #5 ACLK = ~ACLK;

    always @(posedge ACLK) begin
        if (map_rd_en) rd_q <= tmap[map_addr];
    end
    assign map_rd_data = rd_q;

    // scoreboard: every read and every buffer write must match the head of its queue
    always @(negedge ACLK) begin
        if (map_rd_en) begin
            checks++;
            if (exp_addr_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected addr=%h required=none", map_addr);
            end else begin
                ea = exp_addr_q.pop_front();
                if (map_addr !== ea) begin
                    failures++;
                    $display("FAIL rd_addr got=%h required=%h", map_addr, ea);
                end
            end
        end
        if (buf_wr_en) begin
            checks++;
            if (exp_wr_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected slot=%0d tile=%h required=none", buf_wr_addr, buf_wr_tile);
            end else begin
                ew = exp_wr_q.pop_front();
                if ({buf_wr_addr, buf_wr_tile} !== ew) begin
                    failures++;
                    $display("FAIL wr_data got slot=%0d tile=%h required slot=%0d tile=%h",
                             buf_wr_addr, buf_wr_tile, ew[13:8], ew[7:0]);
                end
            end
        end
    end

    task automatic push_expected(input logic [9:0] ly, input logic [9:0] sx, input logic [9:0] sy);
        logic [9:0]  my;
        logic [5:0]  c0;
        logic [5:0]  col;
        logic [11:0] a;
        my = ly + sy;
        c0 = sx[9:4];
        for (int k = 0; k < 41; k++) begin
            col = c0 + 6'(k);
            a = {my[9:4], col};
            exp_addr_q.push_back(a);
            exp_wr_q.push_back({6'(k), tmap[a]});
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({map_rd_en, map_addr, buf_wr_en, buf_wr_addr, buf_wr_tile, fine_x, fine_row,
             busy, line_done, overrun_cnt} !== '0) begin
            failures++;
            $display("FAIL %s outputs not zero: rd=%b addr=%h wr=%b slot=%0d tile=%h fx=%0d fr=%0d busy=%b done=%b ovr=%0d required all 0",
                     tag, map_rd_en, map_addr, buf_wr_en, buf_wr_addr, buf_wr_tile, fine_x,
                     fine_row, busy, line_done, overrun_cnt);
        end
    endtask

    task automatic run_line(input logic [9:0] ly, input logic [9:0] sx, input logic [9:0] sy,
                            input int ov0, input int ov1, input int ov2, input bit ov_all);
        logic [9:0] my;
        int nov;
        nov = 0;
        my = ly + sy;
        push_expected(ly, sx, sy);
        @(negedge ACLK);
        cfg_enable = 1'b1;
        cfg_scroll_x = sx;
        cfg_scroll_y = sy;
        line_y = ly;
        line_start = 1'b1;
        for (int c = 1; c <= 44; c++) begin
            @(negedge ACLK);
            if (c <= 41) obs_addr[c-1] = map_addr;
            checks++;
            if (busy !== (c <= 43)) begin
                failures++;
                $display("FAIL busy cycle=%0d got=%b required=%b", c, busy, (c <= 43));
            end
            checks++;
            if (map_rd_en !== (c <= 41)) begin
                failures++;
                $display("FAIL rd_en cycle=%0d got=%b required=%b", c, map_rd_en, (c <= 41));
            end
            checks++;
            if (buf_wr_en !== (c >= 2 && c <= 42)) begin
                failures++;
                $display("FAIL wr_en cycle=%0d got=%b required=%b", c, buf_wr_en, (c >= 2 && c <= 42));
            end
            checks++;
            if (line_done !== (c == 43)) begin
                failures++;
                $display("FAIL line_done cycle=%0d got=%b required=%b", c, line_done, (c == 43));
            end
            checks++;
            if (fine_x !== sx[3:0] || fine_row !== my[3:0]) begin
                failures++;
                $display("FAIL fine cycle=%0d got fx=%0d fr=%0d required fx=%0d fr=%0d",
                         c, fine_x, fine_row, sx[3:0], my[3:0]);
            end
            line_start = ov_all ? (c <= 43) : (c == ov0 || c == ov1 || c == ov2);
            if (line_start) nov++;
            if (c == 10) begin
                cfg_scroll_x = ~sx;
                cfg_scroll_y = ~sy;
                line_y = ~ly;
            end
        end
        line_start = 1'b0;
        exp_ovr = (exp_ovr + nov > 255) ? 255 : exp_ovr + nov;
        checks++;
        if (overrun_cnt !== 8'(exp_ovr)) begin
            failures++;
            $display("FAIL overrun_cnt got=%0d required=%0d", overrun_cnt, exp_ovr);
        end
        checks++;
        if (exp_addr_q.size() != 0 || exp_wr_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover reads=%0d writes=%0d required 0 0", exp_addr_q.size(), exp_wr_q.size());
        end
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        cfg_enable = 1'b1;
        cfg_scroll_x = 10'h123;
        cfg_scroll_y = 10'h0AB;
        line_y = 10'd7;
        line_start = 1'b1;
        repeat (3) @(negedge ACLK);
        check_all_zero("reset_hold");
        line_start = 1'b0;
        ARESET = 1'b0;
        repeat (3) @(negedge ACLK);
        check_all_zero("reset_release");
    endtask

    task automatic test_basic();
        run_line(10'd0, 10'd0, 10'd0, 0, 0, 0, 1'b0);
        checks++;
        if (obs_addr[0] !== 12'h000 || obs_addr[1] !== 12'h001 || obs_addr[40] !== 12'h028) begin
            failures++;
            $display("FAIL basic_addr got %h %h %h required 000 001 028", obs_addr[0], obs_addr[1], obs_addr[40]);
        end
    endtask

    task automatic test_col_wrap();
        run_line(10'd3, 10'h3F5, 10'h010, 0, 0, 0, 1'b0);
        checks++;
        if (obs_addr[0] !== 12'h07F || obs_addr[1] !== 12'h040 || obs_addr[2] !== 12'h041 ||
            obs_addr[40] !== 12'h067) begin
            failures++;
            $display("FAIL col_wrap got %h %h %h %h required 07f 040 041 067",
                     obs_addr[0], obs_addr[1], obs_addr[2], obs_addr[40]);
        end
        checks++;
        if (fine_x !== 4'd5 || fine_row !== 4'd3) begin
            failures++;
            $display("FAIL col_wrap_fine got fx=%0d fr=%0d required fx=5 fr=3", fine_x, fine_row);
        end
    endtask

    task automatic test_vert_wrap();
        run_line(10'd5, 10'd0, 10'h3FE, 0, 0, 0, 1'b0);
        checks++;
        if (obs_addr[0] !== 12'h000 || obs_addr[40] !== 12'h028 || fine_row !== 4'd3) begin
            failures++;
            $display("FAIL vert_wrap got a0=%h a40=%h fr=%0d required 000 028 3", obs_addr[0], obs_addr[40], fine_row);
        end
    endtask

    task automatic test_overrun();
        run_line(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                 10'($urandom_range(0, 1023)), 10, 20, 43, 1'b0);
        checks++;
        if (overrun_cnt !== 8'd3) begin
            failures++;
            $display("FAIL overrun_three got=%0d required=3", overrun_cnt);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 7; i++)
            run_line(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                     10'($urandom_range(0, 1023)), 0, 0, 0, 1'b1);
        checks++;
        if (overrun_cnt !== 8'd255) begin
            failures++;
            $display("FAIL overrun_sat got=%0d required=255", overrun_cnt);
        end
    endtask

    task automatic test_disabled();
        @(negedge ACLK);
        cfg_enable = 1'b0;
        line_y = 10'd9;
        line_start = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge ACLK);
            line_start = (c < 3);
            checks++;
            if (map_rd_en !== 1'b0 || buf_wr_en !== 1'b0 || line_done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL disabled cycle=%0d rd=%b wr=%b done=%b busy=%b required 0 0 0 0",
                         c, map_rd_en, buf_wr_en, line_done, busy);
            end
        end
        checks++;
        if (overrun_cnt !== 8'(exp_ovr)) begin
            failures++;
            $display("FAIL disabled_ovr got=%0d required=%0d", overrun_cnt, exp_ovr);
        end
        cfg_enable = 1'b1;
    endtask

    task automatic test_random_lines();
        for (int i = 0; i < 4; i++)
            run_line(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                     10'($urandom_range(0, 1023)), 0, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_fetch();
        push_expected(10'd100, 10'h2C7, 10'h155);
        @(negedge ACLK);
        cfg_enable = 1'b1;
        cfg_scroll_x = 10'h2C7;
        cfg_scroll_y = 10'h155;
        line_y = 10'd100;
        line_start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge ACLK);
            line_start = 1'b0;
        end
        ARESET = 1'b1;
        @(negedge ACLK);
        check_all_zero("reset_mid");
        checks++;
        if (exp_addr_q.size() != 21 || exp_wr_q.size() != 22) begin
            failures++;
            $display("FAIL reset_mid_progress reads_left=%0d writes_left=%0d required 21 22",
                     exp_addr_q.size(), exp_wr_q.size());
        end
        exp_addr_q.delete();
        exp_wr_q.delete();
        exp_ovr = 0;
        ARESET = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge ACLK);
            checks++;
            if (map_rd_en !== 1'b0 || buf_wr_en !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_quiet cycle=%0d rd=%b wr=%b busy=%b required 0 0 0",
                         c, map_rd_en, buf_wr_en, busy);
            end
        end
        run_line(10'd44, 10'h0F3, 10'h201, 0, 0, 0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) tmap[i] = 8'($urandom_range(0, 255));
        ARESET = 1'b1;
        cfg_enable = 1'b0;
        cfg_scroll_x = '0;
        cfg_scroll_y = '0;
        line_start = 1'b0;
        line_y = '0;
        test_reset();
        test_basic();
        test_col_wrap();
        test_vert_wrap();
        test_overrun();
        test_saturate();
        test_disabled();
        test_random_lines();
        test_reset_mid_fetch();
        repeat (2) @(negedge ACLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
